byte_demux8: RTL

BYTE_DEMUX8 -- requirements
Module: byte_demux8

---
 rtl/byte_demux8_pkg.sv | 15 +
 rtl/byte_demux8_if.sv | 25 ++
 rtl/byte_demux8_lane_reg8.sv | 23 ++
 rtl/byte_demux8.sv | 110 +++++++++++
 4 files changed

// File: rtl/byte_demux8_pkg.sv
// rtl/byte_demux8_pkg.sv - shared state encoding and sizes for the byte demux
package byte_demux8_pkg;

  localparam int LANES  = 8;
  localparam int IDX_W  = 3;
  localparam int BYTE_W = 8;
  localparam int WORD_W = LANES * BYTE_W;
  localparam int CNT_W  = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/byte_demux8_if.sv
// rtl/byte_demux8_if.sv - byte input / word output handshake bundle
interface byte_demux8_if;
  import byte_demux8_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [WORD_W-1:0] out_word;
  logic [CNT_W-1:0]  out_count;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  lane_ptr;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_word, out_count, out_valid, lane_ptr
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_word, out_count, out_valid, lane_ptr
  );

endinterface

// File: rtl/byte_demux8_lane_reg8.sv
// rtl/byte_demux8_lane_reg8.sv - one lane register; a write beats a clear in the same cycle
module lane_reg8 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/byte_demux8.sv
// rtl/byte_demux8.sv - steers bytes into 8 lanes and hands out assembled words
module byte_demux8
  import byte_demux8_pkg::*;
#(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  byte_demux8_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   lane_ptr;
  logic [CNT_W-1:0]   out_count;
  logic               out_valid;
  logic               in_ready;
  logic               in_xfer;
  logic               out_xfer;
  logic               closing;
  logic [IDX_W-1:0]   wr_idx;
  logic [LANES-1:0]   lane_we;
  logic [W-1:0]       lane_q [LANES];
  logic [LANES*W-1:0] word;

  assign in_xfer  = bus.in_valid & in_ready;
  assign out_xfer = out_valid & bus.out_ready;
  // An input transfer closes the word when it fills lane 7 or rides with flush.
  assign closing  = in_xfer & ((lane_ptr == IDX_W'(LANES - 1)) | bus.flush);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (closing) begin
          state_nxt = FULL;
        end else if (!in_xfer && bus.flush && (lane_ptr != '0)) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = (state == FILL) | bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_ptr  <= '0;
      out_count <= '0;
    end else if (state == FILL) begin
      if (in_xfer) begin
        lane_ptr <= lane_ptr + IDX_W'(1);
        if (closing) begin
          out_count <= {1'b0, lane_ptr} + CNT_W'(1);
        end
      end else if (bus.flush && (lane_ptr != '0)) begin
        out_count <= {1'b0, lane_ptr};
      end
    end else if (out_xfer) begin
      lane_ptr  <= in_xfer ? IDX_W'(1) : '0;
      out_count <= '0;
    end
  end

  // In FULL an accepted byte always belongs to the next word, so it lands in lane 0.
  assign wr_idx = (state == FULL) ? '0 : lane_ptr;

  always_comb begin
    lane_we = '0;
    if (in_xfer) begin
      lane_we[wr_idx] = 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_reg8 #(.W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (out_xfer),
      .we    (lane_we[k]),
      .d     (bus.in_data),
      .q     (lane_q[k])
    );
    assign word[k*W +: W] = lane_q[k];
  end

  assign bus.out_word  = word;
  assign bus.out_count = out_count;
  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready;
  assign bus.lane_ptr  = lane_ptr;

endmodule
